// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with runtime 7/8 data, parity and 1/2 stop configuration
module uart_rx_cfg #(
  parameter int OS_TICKS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  input  logic       d_num,
  input  logic       s_num,
  input  logic [1:0] par,
  input  logic       fifo_full,
  output logic       rx_done_tick,
  output logic [7:0] dout,
  output logic [2:0] err
);
  localparam int SW = $clog2(OS_TICKS);
  localparam logic [SW-1:0] S_MID = SW'(OS_TICKS / 2 - 1);
  localparam logic [SW-1:0] S_END = SW'(OS_TICKS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic rx_d;
  logic [SW-1:0] s;
  logic [2:0] n;
  logic [7:0] b;
  logic d8, s2, p_en, p_odd, perr, ferr;
  logic rx_s, fall, last_data, par_calc;
  assign rx_s      = sync[SYNC_STAGES-1];
  assign fall      = rx_d & ~rx_s;
  assign last_data = n == (d8 ? 3'd7 : 3'd6);
  // b[0] is still stale in 7-bit mode, so it is excluded from the parity sum
  assign par_calc  = ^{d8 & b[0], b[7:1]} ^ rx_s ^ p_odd;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      sync         <= '1;
      rx_d         <= 1'b1;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      d8           <= 1'b0;
      s2           <= 1'b0;
      p_en         <= 1'b0;
      p_odd        <= 1'b0;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      rx_done_tick <= 1'b0;
      dout         <= '0;
      err          <= '0;
    end else begin
      sync         <= {sync[SYNC_STAGES-2:0], rx};
      rx_d         <= rx_s;
      rx_done_tick <= 1'b0;
      err          <= '0;
      case (state)
        IDLE: if (fall) begin
          s     <= '0;
          d8    <= d_num;
          s2    <= s_num;
          p_en  <= ^par;
          p_odd <= par == 2'b10;
          perr  <= 1'b0;
          ferr  <= 1'b0;
          state <= START;
        end
        START: if (s_tick) begin
          if (s == S_MID) begin
            s     <= '0;
            n     <= '0;
            state <= rx_s ? IDLE : DATA;
          end else s <= s + 1'b1;
        end
        DATA: if (s_tick) begin
          if (s == S_END) begin
            s <= '0;
            b <= {rx_s, b[7:1]};
            n <= last_data ? 3'd0 : n + 3'd1;
            if (last_data) state <= p_en ? PARITY : STOP;
          end else s <= s + 1'b1;
        end
        PARITY: if (s_tick) begin
          if (s == S_END) begin
            s     <= '0;
            perr  <= par_calc;
            state <= STOP;
          end else s <= s + 1'b1;
        end
        STOP: if (s_tick) begin
          if (s == S_END) begin
            s <= '0;
            n <= n + 3'd1;
            if (!rx_s) ferr <= 1'b1;
            // outputs are registered here so they are visible during the DONE cycle
            if (n == {2'b0, s2}) begin
              state        <= DONE;
              rx_done_tick <= 1'b1;
              dout         <= d8 ? b : {1'b0, b[7:1]};
              err          <= {fifo_full, ferr | ~rx_s, perr};
            end
          end else s <= s + 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: randomized and directed frames checked against a queue-based frame model
module tb_uart_rx_cfg;
  localparam int OS = 16;
  localparam int TDIV = 4;
  localparam int BIT_CLKS = OS * TDIV;
  logic clk, reset, s_tick, rx, d_num, s_num, fifo_full, rx_done_tick;
  logic [1:0] par;
  logic [7:0] dout;
  logic [2:0] err;
  int checks = 0;
  int fails = 0;
  typedef struct {logic [7:0] d; logic [2:0] e;} exp_t;
  exp_t exp_q[$];

  uart_rx_cfg #(.OS_TICKS(OS), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx), .d_num(d_num), .s_num(s_num),
    .par(par), .fifo_full(fifo_full), .rx_done_tick(rx_done_tick), .dout(dout), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    int t;
    t = 0;
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      t = (t + 1) % TDIV;
      s_tick = (t == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // every cycle: a done must match the oldest expected frame; err must be 0 otherwise
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_done_tick) begin
        if (exp_q.size() == 0) chk("spurious_done", 32'(rx_done_tick), 32'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("dout", 32'(dout), 32'(e.d));
          chk("err", 32'(err), 32'(e.e));
        end
      end else chk("err_idle", 32'(err), 32'd0);
    end
  end

  function automatic logic par_bit(input logic [7:0] d, input logic d8, input logic [1:0] p);
    logic x;
    x = ^(d8 ? d : {1'b0, d[6:0]});
    return (p == 2'b10) ? ~x : x;
  endfunction

  task automatic send_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic d8, input logic [1:0] p,
                            input logic s2, input logic pbit, input logic bad_stop, input logic toggle);
    d_num = d8;
    s_num = s2;
    par = p;
    send_bit(1'b0);
    for (int i = 0; i < (d8 ? 8 : 7); i++) begin
      if (toggle && i == 3) d_num = ~d_num;
      send_bit(data[i]);
    end
    if (p == 2'b01 || p == 2'b10) send_bit(pbit);
    if (s2) send_bit(1'b1);
    send_bit(~bad_stop);
    send_bit(1'b1);
  endtask

  task automatic frame(input logic [7:0] data, input logic d8, input logic [1:0] p, input logic s2,
                       input logic pbit, input logic bad_stop, input logic ff, input logic toggle,
                       input logic [7:0] ed, input logic [2:0] ee);
    exp_t e;
    e.d = ed;
    e.e = ee;
    fifo_full = ff;
    exp_q.push_back(e);
    send_frame(data, d8, p, s2, pbit, bad_stop, toggle);
    chk("missed_done", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    fifo_full = 1'b0;
  endtask

  initial begin
    logic [7:0] data;
    logic d8, s2, flip, bad, ff, pen;
    logic [1:0] p;
    reset = 1'b1;
    rx = 1'b1;
    d_num = 1'b1;
    s_num = 1'b0;
    par = 2'b00;
    fifo_full = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_done", 32'(rx_done_tick), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    send_bit(1'b1);
    frame(8'h55, 1, 2'b00, 0, 0, 0, 0, 0, 8'h55, 3'b000);
    frame(8'h41, 0, 2'b01, 0, 0, 0, 0, 0, 8'h41, 3'b000);
    frame(8'h41, 0, 2'b01, 0, 1, 0, 0, 0, 8'h41, 3'b001);
    frame(8'hA3, 1, 2'b10, 1, 1, 1, 0, 0, 8'hA3, 3'b010);
    frame(8'h5A, 1, 2'b00, 0, 0, 0, 1, 0, 8'h5A, 3'b100);
    // short low glitch must not produce a frame
    rx = 1'b0;
    repeat (BIT_CLKS / 4) @(negedge clk);
    send_bit(1'b1);
    send_bit(1'b1);
    // line break: one frame-error done, no retrigger while held low
    begin
      exp_t e;
      e.d = 8'h00;
      e.e = 3'b010;
      d_num = 1'b1; s_num = 1'b0; par = 2'b00;
      exp_q.push_back(e);
      rx = 1'b0;
      repeat (20 * BIT_CLKS) @(negedge clk);
      send_bit(1'b1);
      send_bit(1'b1);
      chk("break_done", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    frame(8'hC3, 1, 2'b00, 0, 0, 0, 0, 1, 8'hC3, 3'b000);
    frame(8'h35, 0, 2'b00, 0, 0, 0, 0, 0, 8'h35, 3'b000);
    // reset in the middle of DATA
    d_num = 1'b1; s_num = 1'b0; par = 2'b00;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_done", 32'(rx_done_tick), 32'd0);
    chk("midrst_dout", 32'(dout), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    repeat (3) @(negedge clk);
    rx = 1'b1;
    reset = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    frame(8'h7E, 1, 2'b00, 0, 0, 0, 0, 0, 8'h7E, 3'b000);
    for (int k = 0; k < 20; k++) begin
      data = 8'($urandom);
      d8 = 1'($urandom_range(0, 1));
      s2 = 1'($urandom_range(0, 1));
      p = 2'($urandom_range(0, 3));
      flip = ($urandom_range(0, 3) == 0);
      bad = ($urandom_range(0, 3) == 0);
      ff = ($urandom_range(0, 3) == 0);
      pen = (p == 2'b01 || p == 2'b10);
      frame(data, d8, p, s2, par_bit(data, d8, p) ^ flip, bad, ff, 0,
            d8 ? data : {1'b0, data[6:0]}, {ff, bad, flip & pen});
      repeat ($urandom_range(0, 2)) send_bit(1'b1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
